// File: rtl/dma_chan_sched.sv
// Round-robin scheduler that hands channel descriptors to a single DMA engine and reports completion.
// Optional DMA_SCHED_ERR_HALT_EN: channels finishing with a severe error are masked until their irq is cleared.
module dma_chan_sched #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DESC_W     = 2*ADDR_WIDTH+28
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [NUM_CH-1:0]       ch_req_i,
  input  logic [NUM_CH*DESC_W-1:0] ch_desc_i,
  output logic [NUM_CH-1:0]       ch_done_o,
  output logic [NUM_CH*2-1:0]     ch_rd_err_o,
  output logic [NUM_CH*2-1:0]     ch_wr_err_o,
  output logic [NUM_CH-1:0]       ch_busy_o,
`ifdef DMA_SCHED_ERR_HALT_EN
  output logic [NUM_CH-1:0]       ch_halt_o,
`endif
  output logic                    irq_o,
  input  logic [NUM_CH-1:0]       irq_clr_i,
  output logic                    dma_req_o,
  input  logic                    dma_req_ack_i,
  input  logic                    dma_rdy_i,
  input  logic                    dma_rd_done_i,
  input  logic                    dma_wr_done_i,
  input  logic [1:0]              dma_rd_error_i,
  input  logic [1:0]              dma_wr_error_i,
  output logic [11:0]             dma_bytes_o,
  output logic [ADDR_WIDTH-1:0]   dma_rd_addr_o,
  output logic [ADDR_WIDTH-1:0]   dma_wr_addr_o,
  output logic [2:0]              dma_rd_size_o,
  output logic [2:0]              dma_wr_size_o,
  output logic [3:0]              dma_rd_burst_o,
  output logic [3:0]              dma_wr_burst_o,
  output logic                    dma_rd_inc_o,
  output logic                    dma_wr_inc_o
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW    = ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, grant_q, win_idx;
  logic                win_valid, grant_en, complete, req_q;
  logic [NUM_CH-1:0]   eligible, pending_q, done_q, busy_q;
  logic [DESC_W-1:0]   desc_q, win_desc;
  logic [NUM_CH*2-1:0] rd_err_q, wr_err_q;
  int                  arb_idx;

`ifdef DMA_SCHED_ERR_HALT_EN
  logic [NUM_CH-1:0]   halt_q;
  assign eligible  = ch_req_i & ~halt_q;
  assign ch_halt_o = halt_q;
`else
  assign eligible  = ch_req_i;
`endif

  // First eligible requester at or after the round-robin pointer, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    arb_idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      arb_idx = (int'(rr_ptr_q) + i) % NUM_CH;
      if (!win_valid && eligible[arb_idx]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(arb_idx);
      end
    end
  end

  always_comb begin
    win_desc = '0;
    for (int n = 0; n < NUM_CH; n++)
      if (win_idx == PTR_W'(n)) win_desc = ch_desc_i[n*DESC_W +: DESC_W];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: if (win_valid && dma_rdy_i) begin
        grant_en = 1'b1;
        state_d  = REQ;
      end
      REQ:  if (dma_req_ack_i) state_d = BUSY;
      BUSY: if (dma_rdy_i && dma_rd_done_i && dma_wr_done_i) begin
        complete = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant latches the descriptor; completion reports status back to the owning channel.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      desc_q   <= '0;
      req_q    <= 1'b0;
      busy_q   <= '0;
      done_q   <= '0;
      rd_err_q <= '0;
      wr_err_q <= '0;
    end else begin
      done_q <= '0;
      if (grant_en) begin
        grant_q <= win_idx;
        desc_q  <= win_desc;
        req_q   <= 1'b1;
      end
      if (state_q == REQ && dma_req_ack_i) req_q <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        if (grant_en && win_idx == PTR_W'(n)) begin
          busy_q[n]         <= 1'b1;
          rd_err_q[2*n +: 2] <= 2'b00;
          wr_err_q[2*n +: 2] <= 2'b00;
        end
        if (complete && grant_q == PTR_W'(n)) begin
          busy_q[n]         <= 1'b0;
          done_q[n]         <= 1'b1;
          rd_err_q[2*n +: 2] <= dma_rd_error_i;
          wr_err_q[2*n +: 2] <= dma_wr_error_i;
        end
      end
      if (complete) rr_ptr_q <= (grant_q == PTR_W'(NUM_CH-1)) ? '0 : grant_q + 1'b1;
    end
  end

  // A completion and a software clear landing on the same edge leave the flag set.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (complete && grant_q == PTR_W'(n)) pending_q[n] <= 1'b1;
        else if (irq_clr_i[n])                pending_q[n] <= 1'b0;
      end
    end
  end

`ifdef DMA_SCHED_ERR_HALT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      halt_q <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (complete && grant_q == PTR_W'(n) && (dma_rd_error_i[1] || dma_wr_error_i[1]))
          halt_q[n] <= 1'b1;
        else if (irq_clr_i[n])
          halt_q[n] <= 1'b0;
      end
    end
  end
`endif

  assign dma_req_o      = req_q;
  assign ch_busy_o      = busy_q;
  assign ch_done_o      = done_q;
  assign ch_rd_err_o    = rd_err_q;
  assign ch_wr_err_o    = wr_err_q;
  assign irq_o          = |pending_q;

  assign dma_rd_addr_o  = desc_q[AW-1:0];
  assign dma_wr_addr_o  = desc_q[2*AW-1:AW];
  assign dma_bytes_o    = desc_q[2*AW+11:2*AW];
  assign dma_rd_size_o  = desc_q[2*AW+14:2*AW+12];
  assign dma_rd_burst_o = desc_q[2*AW+18:2*AW+15];
  assign dma_rd_inc_o   = desc_q[2*AW+19];
  assign dma_wr_size_o  = desc_q[2*AW+22:2*AW+20];
  assign dma_wr_burst_o = desc_q[2*AW+26:2*AW+23];
  assign dma_wr_inc_o   = desc_q[2*AW+27];

endmodule

// File: tb/tb_dma_chan_sched.sv
// Directed bench for dma_chan_sched: table of round-robin transfers plus hand-written corner sequences.
module tb_dma_chan_sched;

  localparam int NUM_CH     = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DESC_W     = 2*ADDR_WIDTH+28;

  logic                     clk_i = 1'b0;
  logic                     rstn_i = 1'b1;
  logic [NUM_CH-1:0]        ch_req_i;
  logic [NUM_CH*DESC_W-1:0] ch_desc_i;
  logic [NUM_CH-1:0]        ch_done_o;
  logic [NUM_CH*2-1:0]      ch_rd_err_o, ch_wr_err_o;
  logic [NUM_CH-1:0]        ch_busy_o;
`ifdef DMA_SCHED_ERR_HALT_EN
  logic [NUM_CH-1:0]        ch_halt_o;
`endif
  logic                     irq_o;
  logic [NUM_CH-1:0]        irq_clr_i;
  logic                     dma_req_o, dma_req_ack_i, dma_rdy_i;
  logic                     dma_rd_done_i, dma_wr_done_i;
  logic [1:0]               dma_rd_error_i, dma_wr_error_i;
  logic [11:0]              dma_bytes_o;
  logic [ADDR_WIDTH-1:0]    dma_rd_addr_o, dma_wr_addr_o;
  logic [2:0]               dma_rd_size_o, dma_wr_size_o;
  logic [3:0]               dma_rd_burst_o, dma_wr_burst_o;
  logic                     dma_rd_inc_o, dma_wr_inc_o;

  logic [DESC_W-1:0]        descs [NUM_CH];
  logic [DESC_W-1:0]        out_desc;
  logic [NUM_CH-1:0]        pend_m;
  logic [NUM_CH*2-1:0]      err_rd_m, err_wr_m;
  int                       check_count = 0;
  int                       pass_count  = 0;

  typedef struct {
    logic [3:0] clr;
    logic [3:0] req;
    int         ch;
    logic [1:0] rd_err;
    logic [1:0] wr_err;
  } vec_t;

  vec_t vecs [11];

  always #5 clk_i = ~clk_i;

  assign ch_desc_i = {descs[3], descs[2], descs[1], descs[0]};
  assign out_desc  = {dma_wr_inc_o, dma_wr_burst_o, dma_wr_size_o,
                      dma_rd_inc_o, dma_rd_burst_o, dma_rd_size_o,
                      dma_bytes_o, dma_wr_addr_o, dma_rd_addr_o};

  dma_chan_sched #(.NUM_CH(NUM_CH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .ch_req_i(ch_req_i), .ch_desc_i(ch_desc_i),
    .ch_done_o(ch_done_o), .ch_rd_err_o(ch_rd_err_o), .ch_wr_err_o(ch_wr_err_o),
    .ch_busy_o(ch_busy_o),
`ifdef DMA_SCHED_ERR_HALT_EN
    .ch_halt_o(ch_halt_o),
`endif
    .irq_o(irq_o), .irq_clr_i(irq_clr_i), .dma_req_o(dma_req_o),
    .dma_req_ack_i(dma_req_ack_i), .dma_rdy_i(dma_rdy_i),
    .dma_rd_done_i(dma_rd_done_i), .dma_wr_done_i(dma_wr_done_i),
    .dma_rd_error_i(dma_rd_error_i), .dma_wr_error_i(dma_wr_error_i),
    .dma_bytes_o(dma_bytes_o), .dma_rd_addr_o(dma_rd_addr_o), .dma_wr_addr_o(dma_wr_addr_o),
    .dma_rd_size_o(dma_rd_size_o), .dma_wr_size_o(dma_wr_size_o),
    .dma_rd_burst_o(dma_rd_burst_o), .dma_wr_burst_o(dma_wr_burst_o),
    .dma_rd_inc_o(dma_rd_inc_o), .dma_wr_inc_o(dma_wr_inc_o)
  );

  function automatic logic [DESC_W-1:0] make_desc(
    input logic [31:0] rd_addr, input logic [31:0] wr_addr, input logic [11:0] bytes,
    input logic [2:0] rd_size, input logic [3:0] rd_burst, input logic rd_inc,
    input logic [2:0] wr_size, input logic [3:0] wr_burst, input logic wr_inc);
    return {wr_inc, wr_burst, wr_size, rd_inc, rd_burst, rd_size, bytes, wr_addr, rd_addr};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One complete transfer starting from IDLE; returns at the negedge of the done pulse.
  task automatic applyStimulus(input logic [3:0] req, input int exp_ch, input logic [1:0] rd_err,
                               input logic [1:0] wr_err, input logic [3:0] clr_at_done,
                               input string tag);
    logic [3:0] one_hot;
    one_hot  = 4'(1 << exp_ch);
    ch_req_i = req;
    dma_rdy_i = 1'b1;
    @(negedge clk_i);
    err_rd_m[exp_ch*2 +: 2] = 2'b00;
    err_wr_m[exp_ch*2 +: 2] = 2'b00;
    checkOutput({tag, " busy"}, 128'(ch_busy_o), 128'(one_hot));
    checkOutput({tag, " dma_req"}, 128'(dma_req_o), 128'(1'b1));
    checkOutput({tag, " desc"}, 128'(out_desc), 128'(descs[exp_ch]));
    checkOutput({tag, " err at grant"}, 128'({ch_rd_err_o, ch_wr_err_o}), 128'({err_rd_m, err_wr_m}));
    dma_req_ack_i = 1'b1;
    @(negedge clk_i);
    dma_req_ack_i = 1'b0;
    dma_rdy_i = 1'b0;
    checkOutput({tag, " dma_req drop"}, 128'(dma_req_o), 128'(1'b0));
    @(negedge clk_i);
    dma_rdy_i = 1'b1;
    dma_rd_done_i = 1'b1;
    dma_wr_done_i = 1'b1;
    dma_rd_error_i = rd_err;
    dma_wr_error_i = wr_err;
    irq_clr_i = clr_at_done;
    @(negedge clk_i);
    dma_rd_done_i = 1'b0;
    dma_wr_done_i = 1'b0;
    dma_rd_error_i = 2'b00;
    dma_wr_error_i = 2'b00;
    irq_clr_i = '0;
    pend_m = (pend_m & ~clr_at_done) | one_hot;
    err_rd_m[exp_ch*2 +: 2] = rd_err;
    err_wr_m[exp_ch*2 +: 2] = wr_err;
    checkOutput({tag, " done"}, 128'(ch_done_o), 128'(one_hot));
    checkOutput({tag, " busy clr"}, 128'(ch_busy_o), 128'(0));
    checkOutput({tag, " err"}, 128'({ch_rd_err_o, ch_wr_err_o}), 128'({err_rd_m, err_wr_m}));
    checkOutput({tag, " irq"}, 128'(irq_o), 128'(|pend_m));
    ch_req_i = req & ~one_hot;
  endtask

  initial begin
    logic [DESC_W-1:0] saved;
    ch_req_i = '0; irq_clr_i = '0; dma_req_ack_i = 1'b0; dma_rdy_i = 1'b1;
    dma_rd_done_i = 1'b0; dma_wr_done_i = 1'b0; dma_rd_error_i = '0; dma_wr_error_i = '0;
    pend_m = '0; err_rd_m = '0; err_wr_m = '0;
    descs[0] = make_desc(32'h0000_0100, 32'h0000_0800, 12'h010, 3'd3, 4'h1, 1'b1, 3'd1, 4'h7, 1'b0);
    descs[1] = make_desc(32'h0000_1000, 32'h0000_2000, 12'h040, 3'd2, 4'h0, 1'b1, 3'd2, 4'h0, 1'b1);
    descs[2] = make_desc(32'h3000_0000, 32'h4000_0000, 12'hFFF, 3'd0, 4'hF, 1'b0, 3'd7, 4'hA, 1'b1);
    descs[3] = make_desc(32'hDEAD_BEE0, 32'h0BAD_F00D, 12'h000, 3'd1, 4'h2, 1'b1, 3'd4, 4'h5, 1'b0);

    vecs[0]  = '{4'b0000, 4'b1111, 0, 2'b00, 2'b00};
    vecs[1]  = '{4'b0000, 4'b1110, 1, 2'b00, 2'b00};
    vecs[2]  = '{4'b0000, 4'b1100, 2, 2'b00, 2'b00};
    vecs[3]  = '{4'b0000, 4'b1000, 3, 2'b00, 2'b00};
    vecs[4]  = '{4'b0000, 4'b0101, 0, 2'b00, 2'b00};
    vecs[5]  = '{4'b0000, 4'b0100, 2, 2'b00, 2'b00};
    vecs[6]  = '{4'b0000, 4'b0110, 1, 2'b00, 2'b00};
    vecs[7]  = '{4'b0000, 4'b0011, 0, 2'b00, 2'b00};
    vecs[8]  = '{4'b0000, 4'b0100, 2, 2'b10, 2'b00};
    vecs[9]  = '{4'b0100, 4'b1000, 3, 2'b00, 2'b01};
    vecs[10] = '{4'b0000, 4'b0100, 2, 2'b00, 2'b00};

    #2 rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("reset dma_req", 128'(dma_req_o), 128'(0));
    checkOutput("reset busy/done/irq", 128'({ch_busy_o, ch_done_o, irq_o}), 128'(0));
    checkOutput("reset err", 128'({ch_rd_err_o, ch_wr_err_o}), 128'(0));
    checkOutput("reset desc", 128'(out_desc), 128'(0));
    rstn_i = 1'b1;
    @(negedge clk_i);

    applyStimulus(4'b0010, 1, 2'b00, 2'b00, 4'b0000, "single");
    @(negedge clk_i);
    checkOutput("single done once", 128'(ch_done_o), 128'(0));
    checkOutput("single irq held", 128'(irq_o), 128'(1));
    checkOutput("single rd_addr", 128'(dma_rd_addr_o), 128'(32'h1000));
    checkOutput("single wr_addr", 128'(dma_wr_addr_o), 128'(32'h2000));
    checkOutput("single bytes", 128'(dma_bytes_o), 128'(12'h040));
    checkOutput("single size/inc", 128'({dma_rd_size_o, dma_rd_inc_o}), 128'({3'd2, 1'b1}));
    irq_clr_i = 4'b0010;
    @(negedge clk_i);
    irq_clr_i = '0;
    pend_m &= ~4'b0010;
    checkOutput("single irq clr", 128'(irq_o), 128'(0));

    saved = descs[3];
    ch_req_i = 4'b1000;
    @(negedge clk_i);
    checkOutput("stall grant", 128'(ch_busy_o), 128'(4'b1000));
    for (int c = 0; c < 10; c++) begin
      descs[3] = DESC_W'({$urandom(), $urandom(), $urandom()});
      @(negedge clk_i);
      checkOutput("stall dma_req", 128'(dma_req_o), 128'(1));
      checkOutput("stall desc", 128'(out_desc), 128'(saved));
    end
    descs[3] = saved;
    dma_req_ack_i = 1'b1;
    @(negedge clk_i);
    dma_req_ack_i = 1'b0;
    dma_rdy_i = 1'b0;
    checkOutput("stall ack drop", 128'(dma_req_o), 128'(0));
    @(negedge clk_i);
    checkOutput("busy desc held", 128'(out_desc), 128'(saved));
    rstn_i = 1'b0;
    #1;
    checkOutput("midreset busy/req", 128'({ch_busy_o, dma_req_o}), 128'(0));
    checkOutput("midreset desc", 128'(out_desc), 128'(0));
    ch_req_i = '0;
    dma_rdy_i = 1'b1;
    pend_m = '0; err_rd_m = '0; err_wr_m = '0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    checkOutput("post reset idle", 128'({ch_busy_o, dma_req_o, irq_o}), 128'(0));

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].clr != 4'b0000) begin
        ch_req_i = '0;
        irq_clr_i = vecs[i].clr;
        @(negedge clk_i);
        irq_clr_i = '0;
        pend_m &= ~vecs[i].clr;
        checkOutput($sformatf("vec%0d clr irq", i), 128'(irq_o), 128'(|pend_m));
      end
      applyStimulus(vecs[i].req, vecs[i].ch, vecs[i].rd_err, vecs[i].wr_err, 4'b0000,
                    $sformatf("vec%0d", i));
    end

    irq_clr_i = 4'b1111;
    @(negedge clk_i);
    irq_clr_i = '0;
    pend_m = '0;
    checkOutput("clear all irq", 128'(irq_o), 128'(0));
    applyStimulus(4'b0001, 0, 2'b00, 2'b00, 4'b0001, "collide");
    @(negedge clk_i);
    checkOutput("collide pending kept", 128'(irq_o), 128'(1));

`ifdef DMA_SCHED_ERR_HALT_EN
    applyStimulus(4'b0001, 0, 2'b00, 2'b11, 4'b0000, "halt_set");
    ch_req_i = 4'b0001;
    checkOutput("halt flag", 128'(ch_halt_o), 128'(4'b0001));
    repeat (3) @(negedge clk_i);
    checkOutput("halt masked", 128'({ch_busy_o, dma_req_o}), 128'(0));
    irq_clr_i = 4'b0001;
    @(negedge clk_i);
    irq_clr_i = '0;
    pend_m &= ~4'b0001;
    checkOutput("halt cleared", 128'(ch_halt_o), 128'(0));
    applyStimulus(4'b0001, 0, 2'b00, 2'b00, 4'b0000, "halt_regrant");
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/dma_chan_sched.md
Name: dma_chan_sched

Overview:
- Multi-channel scheduler for the single DMA engine. Arbitrates round-robin among NUM_CH requesting channels.
- On grant, latches the winning channel's packed descriptor and drives it onto the engine's request/config inputs. Holds the request until the engine acknowledges it, then waits for completion.
- On completion, returns per-channel done/error status and an interrupt.
- Sits between register-file channel descriptors and the DMA engine's request interface.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- ADDR_WIDTH, 32, engine address width.
- DESC_W, 2*ADDR_WIDTH+28, packed descriptor width.
  - Bit layout, msb..lsb: wr_inc[1], wr_burst[4], wr_size[3], rd_inc[1], rd_burst[4], rd_size[3], bytes[12], wr_addr[ADDR_WIDTH], rd_addr[ADDR_WIDTH].

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- ch_req_i  in  NUM_CH  level request per channel
- ch_desc_i  in  NUM_CH*DESC_W  descriptors; channel n occupies bits [n*DESC_W +: DESC_W]
- ch_done_o  out  NUM_CH  one-cycle completion pulse per channel
- ch_rd_err_o  out  NUM_CH*2  latched rresp error per channel
- ch_wr_err_o  out  NUM_CH*2  latched bresp error per channel
- ch_busy_o  out  NUM_CH  one-hot: channel currently owning the engine
- irq_o  out  1  level; OR of pending done flags
- irq_clr_i  in  NUM_CH  write-1-clear of pending flags
- dma_req_o  out  1  engine request
- dma_req_ack_i  in  1  engine acknowledge
- dma_rdy_i  in  1  engine idle
- dma_rd_done_i  in  1  engine read-side done
- dma_wr_done_i  in  1  engine write-side done
- dma_rd_error_i  in  2  engine read error
- dma_wr_error_i  in  2  engine write error
- dma_bytes_o  out  12  transfer byte count
- dma_rd_addr_o / dma_wr_addr_o  out  ADDR_WIDTH  source / destination address
- dma_rd_size_o / dma_wr_size_o  out  3  beat size
- dma_rd_burst_o / dma_wr_burst_o  out  4  burst code
- dma_rd_inc_o / dma_wr_inc_o  out  1  address increment enable

Behaviour:
- Reset values:
  - All outputs 0.
  - Round-robin pointer = channel 0; state IDLE; pending flags 0.
- State machine:
  - IDLE: if any ch_req_i is set and dma_rdy_i=1, grant the first requester at or after the RR pointer (wrapping). On that edge, latch the grant index and descriptor into the dma_* output registers, set ch_busy_o, and go to REQ.
  - REQ: hold dma_req_o=1. When dma_req_ack_i=1, drop dma_req_o on the next edge and go to BUSY.
  - BUSY: wait for dma_rdy_i=1 & dma_wr_done_i=1 & dma_rd_done_i=1. Then capture dma_rd_error_i/dma_wr_error_i into the granted channel's error fields, pulse ch_done_o[g] for one cycle, set pending[g], clear ch_busy_o, set RR pointer to (g+1) mod NUM_CH, and go to IDLE.
- Latency:
  - req-to-dma_req_o: 1 cycle.
  - Back-to-back grant: earliest 1 cycle after the done pulse.
- Descriptor stability: descriptor outputs are stable from grant until BUSY exit. Changes to ch_desc_i after grant are ignored.
- Request ownership: ch_req_i is level. A channel whose ch_req_i remains high after done is re-arbitrated normally, so the requester must drop it on ch_done_o.
- bytes=0 descriptor: granted and forwarded unchanged; completion is still reported when the engine returns idle.
- Error fields: held until that channel's next grant, which clears both fields on the grant edge.
- Interrupt:
  - irq_o = |pending.
  - irq_clr_i[n] clears pending[n].
  - If a set and a clear hit the same channel in the same cycle, set wins.
- ch_req_i dropped while in REQ/BUSY: transfer continues to completion and done is still reported (no abort).
- Async reset mid-transfer: scheduler returns to IDLE immediately; the engine is reset by the same rstn_i.

Optional Feature:
- Macro: DMA_SCHED_ERR_HALT_EN.
- Defined:
  - Any nonzero error bit [1] at completion sets halt[g].
  - A halted channel is masked from arbitration until irq_clr_i[g]=1, which clears both pending[g] and halt[g].
  - Added output ch_halt_o[NUM_CH], reset 0.
- Undefined: no halt logic; errored channels remain eligible. The ch_halt_o port is absent.

Test Plan:
- Single transfer, ch1:
  - Stimulus: ch_req_i=4'b0010; desc rd_addr=0x1000, wr_addr=0x2000, bytes=0x040, size=2, inc=1.
  - Required: dma_req_o rises 1 cycle later; dma_rd_addr_o=0x1000; ch_done_o[1] pulses once; irq_o=1 until irq_clr_i[1].
- Round-robin:
  - Stimulus: ch_req_i=4'b1111 held, each requester dropping its request on its own done pulse.
  - Required: grant order 0,1,2,3. Then with requests 0 and 2 re-raised and pointer at 0, grant 0 then 2.
- Read error:
  - Stimulus: engine returns dma_rd_error_i=2'b10 at completion for ch2.
  - Required: ch_rd_err_o[5:4]=2'b10, ch_wr_err_o[5:4]=0, held until ch2's next grant clears them.
- Ack stall:
  - Stimulus: dma_req_ack_i held low 10 cycles.
  - Required: dma_req_o and all descriptor outputs constant for all 10 cycles; ch_desc_i changes ignored.
- Set/clear collision:
  - Stimulus: irq_clr_i[0]=1 in the same cycle as ch_done_o[0].
  - Required: pending[0] remains 1.
- Halt (with DMA_SCHED_ERR_HALT_EN):
  - Stimulus: ch0 completes with dma_wr_error_i=2'b11 while ch0 keeps requesting.
  - Required: ch_halt_o[0]=1 and ch0 is not granted. After irq_clr_i[0], ch0 is granted again.
